mem_bank_prog_ctrl: RTL and testbench

MEM_BANK_PROG_CTRL -- requirements
Module: mem_bank_prog_ctrl

---
 rtl/mem_bank_prog_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_bank_prog_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_prog_ctrl.sv
// Memory-bank programming controller.
// Streams one row of bitline data in DATA_W-wide words, then strobes that
// row's wordline for WL_PULSE cycles, and repeats this for every row.
// The bitline data is framed by one SETUP cycle and one HOLD cycle, so bl is
// stable for the whole wordline pulse. All outputs come straight from flops.

// Property checker for the controller outputs; bound inside the top module.
module mem_bank_prog_ctrl_chk #(
  parameter int NUM_WL = 4,
  parameter int NUM_BL = 40
) (
  input logic              prog_clk,
  input logic              prog_reset,
  input logic              s_ready,
  input logic              cfg_busy,
  input logic [NUM_BL-1:0] bl,
  input logic [NUM_WL-1:0] wl
);

  a_wl_onehot: assert property (@(posedge prog_clk) disable iff (prog_reset)
    $onehot0(wl));

  a_bl_stable_in_pulse: assert property (@(posedge prog_clk) disable iff (prog_reset)
    (wl != '0) |-> $stable(bl));

  a_ready_implies_busy: assert property (@(posedge prog_clk) disable iff (prog_reset)
    s_ready |-> cfg_busy);

endmodule

module mem_bank_prog_ctrl #(
  parameter int NUM_WL   = 4,
  parameter int NUM_BL   = 40,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int NUM_WORDS = NUM_BL / DATA_W;
  localparam int WORD_CW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int ROW_CW    = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int PULSE_CW  = 4;

  localparam logic [WORD_CW-1:0]  LAST_WORD  = WORD_CW'(NUM_WORDS - 1);
  localparam logic [ROW_CW-1:0]   LAST_ROW   = ROW_CW'(NUM_WL - 1);
  localparam logic [PULSE_CW-1:0] LAST_PULSE = PULSE_CW'(WL_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_r;
  logic [ROW_CW-1:0]   row_cnt_r;
  logic [WORD_CW-1:0]  word_cnt_r;
  logic [PULSE_CW-1:0] pulse_cnt_r;
  logic [NUM_BL-1:0]   bl_reg_r;

  logic                s_ready_r;
  logic [NUM_BL-1:0]   bl_r;
  logic [NUM_WL-1:0]   wl_r;
  logic                cfg_busy_r;
  logic                cfg_done_r;

  logic [NUM_BL-1:0]   bl_wr_s;
  logic [NUM_WL-1:0]   wl_row_s;

  // Row image with the incoming stream word merged in at the current word slot.
  always_comb begin
    bl_wr_s = bl_reg_r;
    bl_wr_s[int'(word_cnt_r) * DATA_W +: DATA_W] = s_data;
  end

  // One-hot wordline pattern for the row currently being programmed.
  always_comb begin
    wl_row_s = '0;
    wl_row_s[row_cnt_r] = 1'b1;
  end

  // Sequencer: state, counters, row image and the registered outputs for the next state.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_r     <= IDLE;
      row_cnt_r   <= '0;
      word_cnt_r  <= '0;
      pulse_cnt_r <= '0;
      bl_reg_r    <= '0;
      s_ready_r   <= 1'b0;
      bl_r        <= '0;
      wl_r        <= '0;
      cfg_busy_r  <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cfg_done_r <= 1'b0;
          if (cfg_start) begin
            state_r    <= LOAD;
            row_cnt_r  <= '0;
            word_cnt_r <= '0;
            s_ready_r  <= 1'b1;
            cfg_busy_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        LOAD: begin
          if (s_valid) begin
            bl_reg_r <= bl_wr_s;
            if (word_cnt_r == LAST_WORD) begin
              // Last word of the row: present the completed image with wl low.
              word_cnt_r <= '0;
              state_r    <= SETUP;
              s_ready_r  <= 1'b0;
              bl_r       <= bl_wr_s;
            end else begin
              word_cnt_r <= word_cnt_r + WORD_CW'(1);
            end
          end else begin
            state_r <= LOAD;
          end
        end

        SETUP: begin
          state_r     <= PULSE;
          pulse_cnt_r <= '0;
          wl_r        <= wl_row_s;
        end

        PULSE: begin
          if (pulse_cnt_r == LAST_PULSE) begin
            state_r     <= HOLD;
            pulse_cnt_r <= '0;
            wl_r        <= '0;
          end else begin
            pulse_cnt_r <= pulse_cnt_r + PULSE_CW'(1);
          end
        end

        HOLD: begin
          bl_r <= '0;
          if (row_cnt_r == LAST_ROW) begin
            state_r    <= DONE;
            cfg_busy_r <= 1'b0;
            cfg_done_r <= 1'b1;
          end else begin
            state_r   <= LOAD;
            row_cnt_r <= row_cnt_r + ROW_CW'(1);
            s_ready_r <= 1'b1;
          end
        end

        DONE: begin
          state_r    <= IDLE;
          cfg_done_r <= 1'b0;
        end

        default: begin
          state_r     <= IDLE;
          row_cnt_r   <= '0;
          word_cnt_r  <= '0;
          pulse_cnt_r <= '0;
          s_ready_r   <= 1'b0;
          bl_r        <= '0;
          wl_r        <= '0;
          cfg_busy_r  <= 1'b0;
          cfg_done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_r;
  assign bl       = bl_r;
  assign wl       = wl_r;
  assign cfg_busy = cfg_busy_r;
  assign cfg_done = cfg_done_r;

  mem_bank_prog_ctrl_chk #(
    .NUM_WL (NUM_WL),
    .NUM_BL (NUM_BL)
  ) u_chk (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .s_ready    (s_ready_r),
    .cfg_busy   (cfg_busy_r),
    .bl         (bl_r),
    .wl         (wl_r)
  );

endmodule

// File: tb/tb_mem_bank_prog_ctrl.sv
// Directed bench for mem_bank_prog_ctrl: default build plus a
// two-row, single-cycle-pulse build. Expected per-cycle outputs come from a
// hand-laid phase timeline (LOAD x5, SETUP, PULSE xN, HOLD per row, then DONE).
module tb_mem_bank_prog_ctrl;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_SETUP = 2;
  localparam int P_PULSE = 3;
  localparam int P_HOLD  = 4;
  localparam int P_DONE  = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        prog_reset, cfg_start, s_valid, s_ready, cfg_busy, cfg_done;
  logic [7:0]  s_data;
  logic [39:0] bl;
  logic [3:0]  wl;

  // NUM_WL=2, WL_PULSE=1 DUT
  logic        b_reset, b_start, b_valid, b_ready, b_busy, b_done;
  logic [7:0]  b_data;
  logic [39:0] b_bl;
  logic [1:0]  b_wl;

  mem_bank_prog_ctrl dut (
    .prog_clk   (clk),
    .prog_reset (prog_reset),
    .cfg_start  (cfg_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .bl         (bl),
    .wl         (wl),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done)
  );

  mem_bank_prog_ctrl #(
    .NUM_WL   (2),
    .NUM_BL   (40),
    .DATA_W   (8),
    .WL_PULSE (1)
  ) dut_b (
    .prog_clk   (clk),
    .prog_reset (b_reset),
    .cfg_start  (b_start),
    .s_valid    (b_valid),
    .s_ready    (b_ready),
    .s_data     (b_data),
    .bl         (b_bl),
    .wl         (b_wl),
    .cfg_busy   (b_busy),
    .cfg_done   (b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          ph_q[$];
  int          row_q[$];
  bit          vld_q[$];
  logic [39:0] exp_bl[4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected phase sequence for one default pass; stall cycles sit after the 3rd word of row 1.
  task automatic build_timeline(input int stall_len);
    ph_q.delete(); row_q.delete(); vld_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 5; w++) begin
        ph_q.push_back(P_LOAD); row_q.push_back(r); vld_q.push_back(1'b1);
        if (r == 1 && w == 2) begin
          for (int k = 0; k < stall_len; k++) begin
            ph_q.push_back(P_LOAD); row_q.push_back(r); vld_q.push_back(1'b0);
          end
        end
      end
      ph_q.push_back(P_SETUP); row_q.push_back(r); vld_q.push_back(1'b1);
      for (int p = 0; p < 2; p++) begin
        ph_q.push_back(P_PULSE); row_q.push_back(r); vld_q.push_back(1'b1);
      end
      ph_q.push_back(P_HOLD); row_q.push_back(r); vld_q.push_back(1'b1);
    end
    ph_q.push_back(P_DONE); row_q.push_back(3); vld_q.push_back(1'b1);
    ph_q.push_back(P_IDLE); row_q.push_back(0); vld_q.push_back(1'b1);
    // words 0x00..0x13 in acceptance order, first word in the low byte
    for (int r = 0; r < 4; r++) begin
      exp_bl[r] = '0;
      for (int k = 0; k < 5; k++) exp_bl[r][k*8 +: 8] = 8'(5*r + k);
    end
  endtask

  task automatic run_pass(input int stall_len, input int rst_row, input bit hold_start,
                          input int exp_done_at);
    int  word;
    int  done_at;
    int  ph, r;
    bit  acc;
    logic [3:0]  e_wl;
    logic [39:0] e_bl;
    build_timeline(stall_len);
    word    = 0;
    done_at = 0;
    cfg_start = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'h00;
    step();
    if (!hold_start) cfg_start = 1'b0;
    for (int i = 0; i < ph_q.size(); i++) begin
      ph   = ph_q[i];
      r    = row_q[i];
      e_wl = (ph == P_PULSE) ? (4'b0001 << r) : 4'b0000;
      e_bl = (ph == P_SETUP || ph == P_PULSE || ph == P_HOLD) ? exp_bl[r] : 40'h0;
      check_eq($sformatf("s_ready[%0d]", i), 64'(s_ready), 64'(ph == P_LOAD));
      check_eq($sformatf("busy[%0d]", i), 64'(cfg_busy), 64'(ph >= P_LOAD && ph <= P_HOLD));
      check_eq($sformatf("done[%0d]", i), 64'(cfg_done), 64'(ph == P_DONE));
      check_eq($sformatf("wl[%0d]", i), 64'(wl), 64'(e_wl));
      check_eq($sformatf("bl[%0d]", i), 64'(bl), 64'(e_bl));
      if (ph == P_SETUP && r == 0) check_eq("row0_bl", 64'(bl), 64'h0403020100);
      if (cfg_done && done_at == 0) done_at = i + 1;
      if (ph == P_PULSE && r == rst_row) begin
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        check_eq("rst_wl", 64'(wl), 64'h0);
        check_eq("rst_busy", 64'(cfg_busy), 64'h0);
        check_eq("rst_bl", 64'(bl), 64'h0);
        check_eq("rst_ready", 64'(s_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
          step();
          check_eq("rst_no_done", 64'(cfg_done), 64'h0);
          check_eq("rst_idle", 64'(cfg_busy), 64'h0);
        end
        return;
      end
      s_valid = vld_q[i];
      s_data  = vld_q[i] ? 8'(word) : 8'hEE;
      acc     = (ph == P_LOAD) && vld_q[i];
      step();
      if (acc) word++;
    end
    if (exp_done_at > 0) check_eq("done_latency", 64'(done_at), 64'(exp_done_at));
    // cfg_start still high only in the held-start pass: next pass begins after IDLE
    check_eq("restart_busy", 64'(cfg_busy), 64'(hold_start));
    check_eq("restart_ready", 64'(s_ready), 64'(hold_start));
    cfg_start = 1'b0;
    if (hold_start) begin
      prog_reset = 1'b1;
      step();
      prog_reset = 1'b0;
      step();
    end
  endtask

  initial begin
    int ph, r;
    prog_reset = 1'b1; cfg_start = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
    b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    step(); step(); step();
    // reset wins over cfg_start and an offered stream word
    check_eq("reset_ready", 64'(s_ready), 64'h0);
    check_eq("reset_bl", 64'(bl), 64'h0);
    check_eq("reset_wl", 64'(wl), 64'h0);
    check_eq("reset_busy", 64'(cfg_busy), 64'h0);
    check_eq("reset_done", 64'(cfg_done), 64'h0);
    prog_reset = 1'b0; cfg_start = 1'b0; s_valid = 1'b0;
    b_reset = 1'b0;
    step();
    check_eq("idle_busy", 64'(cfg_busy), 64'h0);

    run_pass(0, -1, 1'b0, 37);   // plain full program
    run_pass(5, -1, 1'b0, 42);   // 5-cycle stream stall in row 1
    run_pass(0, 2, 1'b0, 0);     // reset in first PULSE cycle of row 2
    run_pass(0, -1, 1'b0, 37);   // fresh program from row 0 after the abort
    run_pass(0, -1, 1'b1, 37);   // cfg_start held high throughout

    // two rows, single-cycle pulse, all-ones data
    b_start = 1'b1; b_valid = 1'b1; b_data = 8'hFF;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      r  = i / 8;
      ph = (i == 16) ? P_DONE : (i == 17) ? P_IDLE :
           ((i % 8) < 5) ? P_LOAD : ((i % 8) == 5) ? P_SETUP :
           ((i % 8) == 6) ? P_PULSE : P_HOLD;
      if (i >= 16) r = 1;
      check_eq($sformatf("b_wl[%0d]", i), 64'(b_wl),
               64'((ph == P_PULSE) ? (2'b01 << r) : 2'b00));
      check_eq($sformatf("b_bl[%0d]", i), 64'(b_bl),
               (ph == P_SETUP || ph == P_PULSE || ph == P_HOLD) ? 64'hFF_FFFF_FFFF : 64'h0);
      check_eq($sformatf("b_done[%0d]", i), 64'(b_done), 64'(ph == P_DONE));
      check_eq($sformatf("b_busy[%0d]", i), 64'(b_busy), 64'(ph >= P_LOAD && ph <= P_HOLD));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
